// File: rtl/btb_tag_ctrl_if.sv
// Client-side handshake bundle for the BTB tag controller: fetch lookups,
// their hit/miss responses, and branch-resolution updates.
interface btb_tag_ctrl_if #(
  parameter int PC_W = 32
);
  logic            lookup_valid;
  logic [PC_W-1:0] lookup_pc;
  logic            lookup_ready;
  logic            resp_valid;
  logic            resp_hit;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_inval;
  logic            upd_ready;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_inval,
    input  lookup_ready, resp_valid, resp_hit, upd_ready
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_inval,
    output lookup_ready, resp_valid, resp_hit, upd_ready
  );
endinterface

// File: rtl/btb_tag_ctrl.sv
// Initiator for the single-port BTB tag SRAM: clears every entry after reset,
// then arbitrates fetch lookups and branch updates onto the one RW port.
module btb_tag_ctrl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 21,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  btb_tag_ctrl_if.slave    bus,
  output logic             init_done,
  output logic             sram_csb,
  output logic             sram_web,
  output logic [IDX_W-1:0] sram_addr,
  output logic [TAG_W:0]   sram_din,
  input  logic [TAG_W:0]   sram_dout
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;
  logic             resp_valid_q;
  logic [TAG_W-1:0] lk_tag_q;
  logic             lookup_accept;

  logic [IDX_W-1:0] upd_idx, lk_idx;
  logic [TAG_W-1:0] upd_tag, lk_tag;

  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_idx  = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag  = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset and top PC bits carry no BTB information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.upd_pc[1:0], bus.upd_pc[PC_W-1:IDX_W+TAG_W+2],
                            bus.lookup_pc[1:0], bus.lookup_pc[PC_W-1:IDX_W+TAG_W+2]};

  // One SRAM access per cycle; updates win over lookups.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sram_csb         = 1'b1;
    sram_web         = 1'b1;
    sram_addr        = '0;
    sram_din         = '0;
    bus.lookup_ready = 1'b0;
    bus.upd_ready    = 1'b0;
    lookup_accept    = 1'b0;
    if (!rst) begin
      if (state == S_INIT) begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = clr_cnt;
      end else begin
        bus.upd_ready    = 1'b1;
        bus.lookup_ready = !bus.upd_valid;
        if (bus.upd_valid) begin
          sram_csb  = 1'b0;
          sram_web  = 1'b0;
          sram_addr = upd_idx;
          sram_din  = bus.upd_inval ? '0 : {1'b1, upd_tag};
        end else if (bus.lookup_valid) begin
          sram_csb      = 1'b0;
          sram_addr     = lk_idx;
          lookup_accept = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      clr_cnt      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= lookup_accept;
      if (state == S_INIT) begin
        clr_cnt <= clr_cnt + IDX_W'(1);
        if (clr_cnt == '1) state <= S_RUN;
      end
    end
  end

  // NOTE: lk_tag_q is pure datapath qualified by resp_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lookup_accept) lk_tag_q <= lk_tag;
  end

  assign init_done      = !rst && (state == S_RUN);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_valid_q && sram_dout[TAG_W] &&
                          (sram_dout[TAG_W-1:0] == lk_tag_q);

endmodule

// File: tb/tb_btb_tag_ctrl.sv
// Directed bench for btb_tag_ctrl with a behavioural 256x22 tag SRAM.
module tb_btb_tag_ctrl;
  localparam int IDX_W = 8;
  localparam int TAG_W = 21;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic             sram_csb, sram_web;
  logic [IDX_W-1:0] sram_addr;
  logic [TAG_W:0]   sram_din;
  logic [TAG_W:0]   sram_dout = '0;
  logic [TAG_W:0]   mem [256];

  int vectors     = 0;
  int miscompares = 0;

  btb_tag_ctrl_if #(.PC_W(PC_W)) bus ();

  btb_tag_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic bad;
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({sram_csb, sram_web, init_done, bus.lookup_ready, bus.upd_ready,
         bus.resp_valid, bus.resp_hit} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 1100000",
               {sram_csb, sram_web, init_done, bus.lookup_ready, bus.upd_ready,
                bus.resp_valid, bus.resp_hit});
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #1;
      bad = sram_csb || sram_web || (sram_addr !== IDX_W'(i)) || (sram_din !== '0) ||
            init_done || bus.lookup_ready || bus.upd_ready;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL sweep_cycle_%0d: csb=%b web=%b addr=%h din=%h done=%b expected write addr %h din 0",
                 i, sram_csb, sram_web, sram_addr, sram_din, init_done, i[7:0]);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if ({init_done, sram_csb, bus.lookup_ready, bus.upd_ready} !== 4'b1111) begin
      miscompares++;
      $display("FAIL init_done_256: got done/csb/lrdy/urdy=%b expected 1111",
               {init_done, sram_csb, bus.lookup_ready, bus.upd_ready});
    end
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_1234;
    #1;
    vectors++;
    if ({bus.lookup_ready, sram_csb, sram_web, sram_addr} !== {3'b101, 8'h8D}) begin
      miscompares++;
      $display("FAIL first_lookup_req: got rdy/csb/web/addr=%b/%b/%b/%h expected 1/0/1/8d",
               bus.lookup_ready, sram_csb, sram_web, sram_addr);
    end
    step();
    bus.lookup_valid = 1'b0;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_lookup_resp: got valid/hit=%b expected 10", {bus.resp_valid, bus.resp_hit});
    end
    step();
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b00) begin
      miscompares++;
      $display("FAIL resp_single_cycle: got valid/hit=%b expected 00", {bus.resp_valid, bus.resp_hit});
    end
  endtask

  task automatic test_install;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h0000_4A08;
    bus.upd_inval = 1'b0;
    #1;
    vectors++;
    if ({bus.upd_ready, sram_csb, sram_web, sram_addr, sram_din} !== {3'b100, 8'h82, 22'h200012}) begin
      miscompares++;
      $display("FAIL install_write: got rdy/csb/web=%b addr=%h din=%h expected 100 82 200012",
               {bus.upd_ready, sram_csb, sram_web}, sram_addr, sram_din);
    end
    step();
    bus.upd_valid    = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_4A08;
    step();
    bus.lookup_pc = 32'h0000_4E08;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b11) begin
      miscompares++;
      $display("FAIL install_hit: got valid/hit=%b expected 11", {bus.resp_valid, bus.resp_hit});
    end
    step();
    bus.lookup_valid = 1'b0;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b10) begin
      miscompares++;
      $display("FAIL other_tag_miss: got valid/hit=%b expected 10", {bus.resp_valid, bus.resp_hit});
    end
  endtask

  task automatic test_invalidate;
    step();
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h0000_4A08;
    bus.upd_inval = 1'b1;
    #1;
    vectors++;
    if ({sram_csb, sram_web, sram_addr, sram_din} !== {2'b00, 8'h82, 22'h0}) begin
      miscompares++;
      $display("FAIL inval_write: got csb/web=%b addr=%h din=%h expected 00 82 0",
               {sram_csb, sram_web}, sram_addr, sram_din);
    end
    step();
    bus.upd_valid    = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_4A08;
    step();
    bus.lookup_valid = 1'b0;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b10) begin
      miscompares++;
      $display("FAIL inval_miss: got valid/hit=%b expected 10", {bus.resp_valid, bus.resp_hit});
    end
  endtask

  task automatic test_conflict;
    step();
    bus.upd_valid    = 1'b1;
    bus.upd_pc       = 32'h0000_4A08;
    bus.upd_inval    = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_4A08;
    #1;
    vectors++;
    if ({bus.upd_ready, bus.lookup_ready, sram_web} !== 3'b100) begin
      miscompares++;
      $display("FAIL conflict_arb: got urdy/lrdy/web=%b expected 100",
               {bus.upd_ready, bus.lookup_ready, sram_web});
    end
    step();
    bus.upd_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.lookup_ready, sram_web, bus.resp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL conflict_retry: got lrdy/web/resp_valid=%b expected 110",
               {bus.lookup_ready, sram_web, bus.resp_valid});
    end
    step();
    bus.lookup_valid = 1'b0;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b11) begin
      miscompares++;
      $display("FAIL conflict_hit: got valid/hit=%b expected 11", {bus.resp_valid, bus.resp_hit});
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [4];
    logic        exp_hit [4];
    pcs     = '{32'h0001_0004, 32'h0001_0008, 32'h0001_000C, 32'h8001_0010};
    exp_hit = '{1'b0, 1'b1, 1'b0, 1'b1};
    step();
    bus.upd_valid = 1'b1;
    bus.upd_inval = 1'b0;
    bus.upd_pc    = 32'h0001_000B;
    step();
    bus.upd_pc = 32'h0001_0010;
    step();
    bus.upd_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pcs[k];
      end else begin
        bus.lookup_valid = 1'b0;
      end
      if (k > 0) begin
        vectors++;
        if ({bus.resp_valid, bus.resp_hit} !== {1'b1, exp_hit[k-1]}) begin
          miscompares++;
          $display("FAIL stream_resp_%0d: got valid/hit=%b%b expected 1%b",
                   k - 1, bus.resp_valid, bus.resp_hit, exp_hit[k-1]);
        end
      end
      step();
    end
    vectors++;
    if (bus.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: got resp_valid=%b expected 0", bus.resp_valid);
    end
    // Lookup at edge N, update to the same index at N+1: response sees old data.
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_4E08;
    step();
    bus.lookup_valid = 1'b0;
    bus.upd_valid    = 1'b1;
    bus.upd_pc       = 32'h0000_4E08;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b10) begin
      miscompares++;
      $display("FAIL lookup_before_upd: got valid/hit=%b expected 10", {bus.resp_valid, bus.resp_hit});
    end
    step();
    bus.upd_valid    = 1'b0;
    bus.lookup_valid = 1'b1;
    step();
    bus.lookup_valid = 1'b0;
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b11) begin
      miscompares++;
      $display("FAIL lookup_after_upd: got valid/hit=%b expected 11", {bus.resp_valid, bus.resp_hit});
    end
  endtask

  task automatic test_reset_mid_sweep;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    vectors++;
    if (sram_addr !== 8'd100) begin
      miscompares++;
      $display("FAIL sweep_at_100: got addr=%h expected 64", sram_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({sram_csb, sram_web, init_done} !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_sweep_rst: got csb/web/done=%b expected 110", {sram_csb, sram_web, init_done});
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if ({sram_csb, sram_web, sram_addr} !== {2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL sweep_restart: got csb/web=%b addr=%h expected 00 00", {sram_csb, sram_web}, sram_addr);
    end
    repeat (255) step();
    vectors++;
    if (init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_early: got init_done=%b expected 0 at cycle 255", init_done);
    end
    step();
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_restart: got init_done=%b expected 1 at cycle 256", init_done);
    end
  endtask

  task automatic test_reset_mid_lookup;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h0000_4E08;
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.lookup_ready, sram_csb} !== 3'b101) begin
      miscompares++;
      $display("FAIL rst_lookup_cycle: got rv/lrdy/csb=%b expected 101",
               {bus.resp_valid, bus.lookup_ready, sram_csb});
    end
    step();
    vectors++;
    if ({bus.resp_valid, bus.resp_hit} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_lookup_resp: got valid/hit=%b expected 00", {bus.resp_valid, bus.resp_hit});
    end
    rst              = 1'b0;
    bus.lookup_valid = 1'b0;
  endtask

  initial begin
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_inval    = 1'b0;
    // Pre-load stale valid entries so a missing clear sweep shows up as hits.
    for (int i = 0; i < 256; i++) mem[i] = {1'b1, 21'h000040};
    mem[8'h8D] = {1'b1, 21'h000004};
    test_reset();
    test_install();
    test_invalidate();
    test_conflict();
    test_back_to_back();
    test_reset_mid_sweep();
    test_reset_mid_lookup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
